// File: rtl/taxi_fare_meter.sv
// Purpose : taxi meter; accumulates ride distance and waiting time and builds the fare by adding tariff units (no multipliers).
// Latency : outputs are registered; they update the cycle after a meter tick, and the cycle after the registered start edge.
// Backpr. : none; level inputs are sampled every cycle, and outputs saturate at all-ones instead of wrapping.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high; aborts any ride
//   start_i      level; its rising edge begins a ride, its falling edge ends it (edges taken after one register)
//   pause_i      level; holds all counting (HOLD state); takes priority over waiting_i
//   waiting_i    level; while running, ticks add waiting time instead of distance
//   speedup_i    speed step; distance grows by speedup_i+1 metres per tick
//   night_i      night tariff request, latched at ride start (used only when NIGHT_RATE_EN is defined)
//   distance_o   metres travelled this ride
//   wait_time_o  waiting ticks this ride
//   money_o      current fare in cents
//   state_o      0 IDLE, 1 RUN, 2 HOLD, 3 DONE
// Optional feature macro: NIGHT_RATE_EN (night distance unit = UNIT_FARE + UNIT_FARE/2).
module taxi_fare_meter #(
    parameter int TICK_DIV  = 100,
    parameter int DIST_W    = 32,
    parameter int WAIT_W    = 32,
    parameter int MONEY_W   = 32,
    parameter int BASE_FARE = 1300,
    parameter int BASE_DIST = 3000,
    parameter int UNIT_DIST = 500,
    parameter int UNIT_FARE = 115,
    parameter int WAIT_UNIT = 60,
    parameter int WAIT_FARE = 50
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               waiting_i,
    input  logic [1:0]         speedup_i,
    input  logic               night_i,
    output logic [DIST_W-1:0]  distance_o,
    output logic [WAIT_W-1:0]  wait_time_o,
    output logic [MONEY_W-1:0] money_o,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_DONE = 2'd3} state_t;

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // residual holds at most UNIT_DIST-1 plus one step of up to 4 metres
    localparam int RW  = $clog2(UNIT_DIST + 4);
    localparam int WRW = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;
    localparam logic [MONEY_W-1:0] DAY_UF   = MONEY_W'(UNIT_FARE);
    localparam logic [MONEY_W-1:0] NIGHT_UF = MONEY_W'(UNIT_FARE + (UNIT_FARE >> 1));

    state_t             state_q, state_d;
    logic               start_q, start_d1_q;
    logic [PW-1:0]      presc_q, presc_d;
    logic [DIST_W-1:0]  distance_q, distance_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic [RW-1:0]      resid_q, resid_d;
    logic [WRW-1:0]     wresid_q, wresid_d;

    logic               rise, fall, tick, unit_hit;
    logic [2:0]         step, beyond;
    logic [DIST_W:0]    step_w, dist_sum, over;
    logic [RW-1:0]      resid_sum;
    logic [MONEY_W-1:0] unit_fare, fare_add;
    logic [MONEY_W:0]   money_sum;

`ifdef NIGHT_RATE_EN
    logic night_q, night_d;
    assign unit_fare = night_q ? NIGHT_UF : DAY_UF;
`else
    logic unused_night;
    assign unused_night = night_i;
    assign unit_fare    = DAY_UF;
`endif

    assign rise = start_q & ~start_d1_q;
    assign fall = ~start_q & start_d1_q;
    assign tick = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));

    // Only metres past BASE_DIST are chargeable; a straddling step contributes just its excess.
    assign step      = 3'(speedup_i) + 3'd1;
    assign step_w    = (DIST_W+1)'(step);
    assign dist_sum  = {1'b0, distance_q} + step_w;
    assign over      = dist_sum - (DIST_W+1)'(BASE_DIST);
    assign beyond    = (dist_sum > (DIST_W+1)'(BASE_DIST)) ? ((over < step_w) ? over[2:0] : step) : 3'd0;
    assign resid_sum = resid_q + RW'(beyond);
    assign unit_hit  = resid_sum >= RW'(UNIT_DIST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        distance_d = distance_q;
        wait_d     = wait_q;
        money_d    = money_q;
        resid_d    = resid_q;
        wresid_d   = wresid_q;
        fare_add   = '0;
        money_sum  = '0;
`ifdef NIGHT_RATE_EN
        night_d    = night_q;
`endif
        if (rise) begin
            state_d    = S_RUN;
            presc_d    = '0;
            distance_d = '0;
            wait_d     = '0;
            money_d    = MONEY_W'(BASE_FARE);
            resid_d    = '0;
            wresid_d   = '0;
`ifdef NIGHT_RATE_EN
            night_d    = night_i;
`endif
        end else if (fall) begin
            state_d = S_DONE;
        end else begin
            if (state_q == S_RUN || state_q == S_HOLD) begin
                state_d = pause_i ? S_HOLD : S_RUN;
            end
            if (state_q == S_RUN) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                if (waiting_i) begin
                    wait_d = (&wait_q) ? wait_q : wait_q + WAIT_W'(1);
                    if (wresid_q == WRW'(WAIT_UNIT - 1)) begin
                        wresid_d = '0;
                        fare_add = MONEY_W'(WAIT_FARE);
                    end else begin
                        wresid_d = wresid_q + WRW'(1);
                    end
                end else begin
                    distance_d = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
                    if (unit_hit) begin
                        resid_d  = resid_sum - RW'(UNIT_DIST);
                        fare_add = unit_fare;
                    end else begin
                        resid_d  = resid_sum;
                    end
                end
                money_sum = {1'b0, money_q} + {1'b0, fare_add};
                money_d   = money_sum[MONEY_W] ? '1 : money_sum[MONEY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            start_d1_q <= 1'b0;
            presc_q    <= '0;
            distance_q <= '0;
            wait_q     <= '0;
            money_q    <= '0;
            resid_q    <= '0;
            wresid_q   <= '0;
`ifdef NIGHT_RATE_EN
            night_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            start_d1_q <= start_q;
            presc_q    <= presc_d;
            distance_q <= distance_d;
            wait_q     <= wait_d;
            money_q    <= money_d;
            resid_q    <= resid_d;
            wresid_q   <= wresid_d;
`ifdef NIGHT_RATE_EN
            night_q    <= night_d;
`endif
        end
    end

    assign distance_o  = distance_q;
    assign wait_time_o = wait_q;
    assign money_o     = money_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_taxi_fare_meter.sv
// Purpose : bench for taxi_fare_meter: directed ride scenarios, randomized stimulus, and a small saturating instance.
// Latency : the reference model advances on each rising clock edge; outputs are compared on the falling edge.
// Backpr. : none.
module tb_taxi_fare_meter;
    localparam int TD = 4;
    localparam longint BF = 1300, BD = 3000, UD = 500, UF = 115, WU = 60, WF = 50;
    localparam longint MAX32 = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, pause = 1'b0, waiting = 1'b0, night = 1'b0;
    logic [1:0]  speedup = 2'd0;
    logic [31:0] distance, wait_time, money;
    logic [1:0]  state;

    // small instance used to reach the saturation limits quickly
    logic        s_rst = 1'b1, s_start = 1'b0, s_waiting = 1'b0;
    logic [1:0]  s_speedup = 2'd3;
    logic [11:0] s_distance;
    logic [5:0]  s_wait_time;
    logic [10:0] s_money;
    logic [1:0]  s_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    taxi_fare_meter #(.TICK_DIV(TD)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause), .waiting_i(waiting),
        .speedup_i(speedup), .night_i(night), .distance_o(distance), .wait_time_o(wait_time),
        .money_o(money), .state_o(state)
    );

    taxi_fare_meter #(.TICK_DIV(1), .DIST_W(12), .WAIT_W(6), .MONEY_W(11), .BASE_FARE(1900)) dut_sat (
        .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .pause_i(1'b0), .waiting_i(s_waiting),
        .speedup_i(s_speedup), .night_i(1'b0), .distance_o(s_distance), .wait_time_o(s_wait_time),
        .money_o(s_money), .state_o(s_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (ride-level view) ----------------
    bit     m_sq = 0, m_sp = 0, m_started = 0, m_night = 0;
    int     m_state = 0, m_presc = 0;
    longint m_dist = 0, m_wait = 0;

    // Fare from totals: whole chargeable distance units and whole waiting units.
    function automatic longint exp_money();
        longint du, uf, m;
        if (!m_started) return 0;
        du = (m_dist > BD) ? (m_dist - BD) / UD : 0;
        uf = UF;
`ifdef NIGHT_RATE_EN
        if (m_night) uf = UF + UF / 2;
`endif
        m = BF + uf * du + WF * (m_wait / WU);
        return (m > MAX32) ? MAX32 : m;
    endfunction

    always @(posedge clk) begin : ref_model
        bit rise, fall, tick;
        if (rst) begin
            m_sq = 0; m_sp = 0; m_started = 0; m_night = 0;
            m_state = 0; m_presc = 0; m_dist = 0; m_wait = 0;
        end else begin
            rise = m_sq && !m_sp;
            fall = !m_sq && m_sp;
            tick = (m_state == 1) && (m_presc == TD - 1);
            if (rise) begin
                m_state = 1; m_presc = 0; m_dist = 0; m_wait = 0;
                m_started = 1; m_night = night;
            end else if (fall) begin
                m_state = 3;
            end else begin
                if (tick) begin
                    if (waiting) m_wait = (m_wait + 1 > MAX32) ? MAX32 : m_wait + 1;
                    else         m_dist = (m_dist + speedup + 1 > MAX32) ? MAX32 : m_dist + speedup + 1;
                end
                if (m_state == 1) m_presc = tick ? 0 : m_presc + 1;
                if (m_state == 1 || m_state == 2) m_state = pause ? 2 : 1;
            end
            m_sp = m_sq;
            m_sq = start;
        end
    end

    always @(negedge clk) begin
        check("mdl_distance", distance, m_dist);
        check("mdl_wait_time", wait_time, m_wait);
        check("mdl_money", money, exp_money());
        check("mdl_state", state, m_state);
    end

    // ---------------- directed helpers ----------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_dist(input string tag, input longint target, input int budget);
        int k = 0;
        @(negedge clk);
        while (distance != target[31:0] && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, distance, target);
    endtask

    task automatic wait_wt(input string tag, input longint target, input int budget);
        int k = 0;
        @(negedge clk);
        while (wait_time != target[31:0] && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, wait_time, target);
    endtask

    task automatic new_ride(input logic [1:0] spd, input logic nt);
        start = 1'b0;
        cycles(3);
        check("ride_end_state", state, 2'd3);
        speedup = spd;
        night   = nt;
        start   = 1'b1;
    endtask

    initial begin
        longint exp_night;
        // 1: reset
        cycles(3);
        check("rst_distance", distance, 0);
        check("rst_wait_time", wait_time, 0);
        check("rst_money", money, 0);
        check("rst_state", state, 0);
        rst = 1'b0; s_rst = 1'b0;
        cycles(2);
        check("idle_state", state, 0);

        // 2: base distance boundary, then first unit
        speedup = 2'd0;
        start = 1'b1;
        cycles(3);
        check("start_money", money, BF);
        check("start_state", state, 1);
        wait_dist("base_dist", 3000, 3000 * TD + 50);
        check("base_money", money, 1300);
        wait_dist("unit_dist", 3500, 500 * TD + 50);
        check("unit_money", money, 1415);

        // 3: fast ride, two units
        new_ride(2'd3, 1'b0);
        wait_dist("fast_dist", 4000, 1000 * TD + 50);
        check("fast_money", money, 1530);

        // 4: waiting in traffic
        waiting = 1'b1;
        wait_wt("wait_time", 120, 120 * TD + 50);
        check("wait_dist", distance, 4000);
        check("wait_money", money, 1630);

        // 5: pause over waiting, then end and restart
        pause = 1'b1;
        cycles(400);
        check("hold_state", state, 2);
        check("hold_dist", distance, 4000);
        check("hold_wait", wait_time, 120);
        check("hold_money", money, 1630);
        start = 1'b0;
        cycles(3);
        check("done_state", state, 3);
        check("done_dist", distance, 4000);
        check("done_money", money, 1630);
        start = 1'b1;
        cycles(3);
        check("restart_dist", distance, 0);
        check("restart_wait", wait_time, 0);
        check("restart_money", money, 1300);
        check("restart_hold", state, 2);
        pause = 1'b0; waiting = 1'b0;

        // 6: night tariff (day fare when the feature is not built in)
`ifdef NIGHT_RATE_EN
        exp_night = 1472;
`else
        exp_night = 1415;
`endif
        new_ride(2'd0, 1'b1);
        wait_dist("night_dist", 3500, 3500 * TD + 50);
        check("night_money", money, exp_night);
        new_ride(2'd0, 1'b0);
        night = 1'b1;   // ignored mid-ride
        wait_dist("day_dist", 3500, 3500 * TD + 50);
        check("day_money", money, 1415);

        // saturation on the narrow instance
        s_start = 1'b1;
        cycles(1300);
        check("sat_state", s_state, 1);
        check("sat_dist", s_distance, 12'hFFF);
        check("sat_money", s_money, 11'h7FF);
        s_waiting = 1'b1;
        cycles(100);
        check("sat_wait", s_wait_time, 6'h3F);
        check("sat_dist_hold", s_distance, 12'hFFF);
        check("sat_money_hold", s_money, 11'h7FF);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 299) == 0) start = ~start;
            if ($urandom_range(0, 15) == 0) pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) waiting = ~waiting;
            if ($urandom_range(0, 7) == 0) speedup = 2'($urandom_range(0, 3));
            night = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
